// File: rtl/flappy_pkg.sv
// Shared types and constants for the 8x8 LED Flappy Bird datapath.
package flappy_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef logic [COLS-1:0][ROWS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } game_state_e;

endpackage

// File: rtl/pipe_field_pipe_gen.sv
// Pseudo-random pipe column generator: an 8-bit LFSR picks where the gap opens.
module pipe_gen #(
  parameter int unsigned GAP  = 3,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] pipe_col
);

  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] base;
  logic [7:0] gap_mask;

  // Fold bases that would push the gap past the top row back down.
  always_comb begin
    base = {1'b0, lfsr_q[2:0]};
    if (base > 4'(8 - GAP)) base = base - 4'(GAP);
    for (int r = 0; r < 8; r++) begin
      gap_mask[r] = (4'(r) >= base) && (4'(r) < base + 4'(GAP));
    end
    pipe_col = ~gap_mask;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/pipe_field.sv
// Pipe field: scrolls random pipes right-to-left, detects bird collisions, keeps score,
// and composites the bird onto the pipe buffer for the LED driver.
module pipe_field
  import flappy_pkg::*;
#(
  parameter int unsigned TICK_DIV = 192,
  parameter int unsigned GAP      = 3,
  parameter int unsigned SPACING  = 4,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  frame_t     bird_loc,
  input  logic       bird_lose,
  output frame_t     frame,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SPACING > 1) ? $clog2(SPACING) : 1;

  game_state_e state_q, state_d;
  frame_t      obs_q, obs_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0]  score_q, score_d;
  logic        game_over_q, game_over_d;
  logic        tick, hit, advance;
  logic [7:0]  pipe_col;

  pipe_gen #(
    .GAP  (GAP),
    .SEED (SEED)
  ) u_pipe_gen (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .pipe_col (pipe_col)
  );

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign hit  = |(bird_loc[0] & obs_q[0]);

  always_comb begin
    state_d     = state_q;
    obs_d       = obs_q;
    tick_cnt_d  = tick_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    score_d     = score_q;
    game_over_d = game_over_q;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PLAY;
          tick_cnt_d  = '0;
          spawn_cnt_d = '0;
        end
      end
      PLAY: begin
        // A collision or floor hit pre-empts any scroll scheduled for this cycle.
        if (hit || bird_lose) begin
          state_d     = OVER;
          game_over_d = 1'b1;
        end else begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
          if (tick) begin
            for (int c = 0; c < 7; c++) obs_d[c] = obs_q[c+1];
            advance     = (spawn_cnt_q == '0);
            obs_d[7]    = advance ? pipe_col : 8'h00;
            spawn_cnt_d = (spawn_cnt_q == SW'(SPACING - 1)) ? '0 : spawn_cnt_q + 1'b1;
            if (|obs_q[0] && score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      OVER: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      obs_q       <= '0;
      tick_cnt_q  <= '0;
      spawn_cnt_q <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      obs_q       <= obs_d;
      tick_cnt_q  <= tick_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    for (int c = 0; c < 8; c++) frame[c] = obs_q[c] | bird_loc[c];
  end

  assign game_over = game_over_q;
  assign score     = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Directed self-checking bench for pipe_field with TICK_DIV=4, GAP=3, SPACING=4, SEED=8'hA5.
module tb_pipe_field;

  logic clk = 1'b0;
  logic reset, start, bird_lose;
  logic [7:0][7:0] bird_loc, frame, exp_f;
  logic game_over;
  logic [7:0] score;
  int checks = 0;
  int errors = 0;

  pipe_field #(
    .TICK_DIV (4),
    .GAP      (3),
    .SPACING  (4),
    .SEED     (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bird_loc  (bird_loc),
    .bird_lose (bird_lose),
    .frame     (frame),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, leaving inputs/outputs settled 1 ns after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bird_lose = 1'b0;
    bird_loc = '0;
    bird_loc[0] = 8'h10;
    step(2);
    reset = 1'b0;
  endtask

  // Start pulse; first tick lands 4 edges after this returns.
  task automatic go_play(input logic [7:0] bird);
    bird_loc = '0;
    bird_loc[0] = bird;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_f = '0;
    exp_f[0] = 8'h10;
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_game_over: got %b want 0", game_over);
    end
    checks++;
    if (score !== 8'h00) begin
      errors++;
      $display("FAIL reset_score: got %h want 00", score);
    end
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL reset_frame: got %h want %h", frame, exp_f);
    end
    step(20);
    checks++;
    if (frame !== exp_f || game_over !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_scroll: got frame %h go %b want %h go 0", frame, game_over, exp_f);
    end
  endtask

  task automatic test_scroll_score();
    do_reset();
    go_play(8'h20);
    step(4);  // tick 1
    exp_f = '0;
    exp_f[7] = 8'h1F;
    exp_f[0] = 8'h20;
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL tick1_frame: got %h want %h", frame, exp_f);
    end
    step(16);  // tick 5
    exp_f = '0;
    exp_f[7] = 8'hE3;
    exp_f[3] = 8'h1F;
    exp_f[0] = 8'h20;
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL tick5_frame: got %h want %h", frame, exp_f);
    end
    step(12);  // tick 8
    exp_f = '0;
    exp_f[4] = 8'hE3;
    exp_f[0] = 8'h3F;
    checks++;
    if (frame !== exp_f || score !== 8'h00 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL tick8_frame: got %h sc %h go %b want %h sc 00 go 0",
               frame, score, game_over, exp_f);
    end
    step(4);  // tick 9
    exp_f = '0;
    exp_f[7] = 8'h1F;
    exp_f[3] = 8'hE3;
    exp_f[0] = 8'h20;
    checks++;
    if (score !== 8'h01) begin
      errors++;
      $display("FAIL tick9_score: got %h want 01", score);
    end
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL tick9_frame: got %h want %h", frame, exp_f);
    end
  endtask

  task automatic test_collision_freeze();
    do_reset();
    go_play(8'h20);
    step(32);  // tick 8, pipe 1F in column 0
    bird_loc[0] = 8'h01;
    #1;
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL hit_not_early: got %b want 0", game_over);
    end
    step(1);
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL hit_game_over: got %b want 1", game_over);
    end
    exp_f = '0;
    exp_f[4] = 8'hE3;
    exp_f[0] = 8'h1F;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      step(5);
      start = 1'b0;
      step(5);
    end
    checks++;
    if (frame !== exp_f || score !== 8'h00 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen: got %h sc %h go %b want %h sc 00 go 1",
               frame, score, game_over, exp_f);
    end
    bird_loc[0] = 8'h40;  // frame stays live against frozen obs
    #1;
    exp_f[0] = 8'h5F;
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL over_live_frame: got %h want %h", frame, exp_f);
    end
  endtask

  task automatic test_lose_and_reset();
    do_reset();
    go_play(8'h20);
    step(5);  // tick 1 done, one more cycle in PLAY
    bird_lose = 1'b1;
    step(1);
    bird_lose = 1'b0;
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL lose_game_over: got %b want 1", game_over);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_f = '0;
    exp_f[0] = 8'h20;
    checks++;
    if (game_over !== 1'b0 || score !== 8'h00 || frame !== exp_f) begin
      errors++;
      $display("FAIL reset_from_over: got %h sc %h go %b want %h sc 00 go 0",
               frame, score, game_over, exp_f);
    end
    go_play(8'h20);
    step(4);
    exp_f[7] = 8'h1F;
    checks++;
    if (frame !== exp_f) begin
      errors++;
      $display("FAIL reseed_first_pipe: got %h want %h", frame, exp_f);
    end
  endtask

  task automatic test_hit_on_tick();
    do_reset();
    go_play(8'h20);
    step(35);  // tick 8 plus 3 cycles: tick_cnt == 3
    bird_loc[0] = 8'h01;
    step(1);
    exp_f = '0;
    exp_f[4] = 8'hE3;
    exp_f[0] = 8'h1F;
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL tickhit_game_over: got %b want 1", game_over);
    end
    checks++;
    if (frame !== exp_f || score !== 8'h00) begin
      errors++;
      $display("FAIL tickhit_no_shift: got %h sc %h want %h sc 00", frame, score, exp_f);
    end
    step(8);
    checks++;
    if (frame !== exp_f || score !== 8'h00) begin
      errors++;
      $display("FAIL tickhit_hold: got %h sc %h want %h sc 00", frame, score, exp_f);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bird_lose = 1'b0;
    bird_loc = '0;
    test_reset();
    test_scroll_score();
    test_collision_freeze();
    test_lose_and_reset();
    test_hit_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
